capture_sequencer: RTL and testbench
====================================

// Module: capture_sequencer
// PURPOSE
//   Sequences one logic-analyzer capture: arm, pre-trigger fill, trigger wait, post-trigger count, done.
//   Drives write strobe/address of the circular sample buffer and owns the per-capture step limit.
//   Sits between the host command/config registers and the sample RAM/probe front end.
//   Supports free-running capture (one sample per clock) and single-step capture from an async step input.
// PARAMETERS
//   ADDR_W   10   sample buffer address width; DEPTH = 2**ADDR_W
//   CNT_W    32   width of step-limit and internal sample counters
// PORTS
//   i_clk            in   1       capture clock; all state on posedge
//   i_reset          in   1       asynchronous, active-high reset
//   i_arm            in   1       1-cycle pulse: start capture, latch config
//   i_abort          in   1       1-cycle pulse: cancel capture, return to IDLE
//   i_step_mode      in   1       1 = sample only on i_single_step edges; 0 = every clock
//   i_single_step    in   1       asynchronous step button/line, rising edge = one sample
//   i_pretrig        in   ADDR_W  samples required before trigger is accepted
//   i_step_limit_en  in   1       1 = cap post-trigger samples at i_step_limit
//   i_step_limit     in   CNT_W   post-trigger sample limit
//   i_trigger        in   1       trigger condition from trigger unit, level
//   o_wr_en          out  1       write current probe sample to buffer
//   o_wr_addr        out  ADDR_W  buffer write address
//   o_trig_addr      out  ADDR_W  address holding the trigger sample
//   o_run            out  1       capture in progress (PRE, WAIT, POST)
//   o_done           out  1       capture complete; held until next arm or reset
//   o_state          out  3       IDLE=0 PRE=1 WAIT=2 POST=3 DONE=4
// BEHAVIOUR
// - Reset (async): state IDLE; all outputs 0; counters, address, step synchronizer cleared.
// - Config (step_mode, pretrig, limit_en, limit) latched on accepted arm; input changes mid-capture ignored.
// - pretrig latched as min(i_pretrig, DEPTH-1).
// - Sample strobe S: step_mode=0 -> S=1 every cycle in PRE/WAIT/POST.
//   step_mode=1 -> 2-FF sync of i_single_step + rising-edge detect; S=1 for one cycle per edge.
// - Outputs registered: a cycle with S=1 gives o_wr_en=1 next cycle, o_wr_addr = that sample's slot.
//   Probe data path is delayed one cycle to match.
// - o_wr_addr increments mod DEPTH after each write; wraps DEPTH-1 -> 0; starts at 0 on each arm.
// - post_len = limit_en ? min(limit, DEPTH-pretrig) : DEPTH-pretrig; post_len 0 treated as 1.
//   post_len counts the trigger sample itself.
// - IDLE: arm -> PRE; pre counter cleared.
// - PRE: each S increments pre counter. pre count == pretrig -> WAIT; pretrig=0 -> WAIT directly on arm.
//   i_trigger ignored in PRE.
// - WAIT: on S with i_trigger=1 -> POST.
//   Sample written, o_trig_addr = its address, post counter = 1.
//   If post_len==1 -> DONE instead of POST.
//   Buffer keeps wrapping while waiting; i_trigger without S is ignored.
// - POST: each S increments post counter; counter reaches post_len -> DONE on that same sample.
// - DONE: o_done=1, o_run=0, no writes. arm -> PRE (o_done cleared, address 0).
// - arm outside IDLE/DONE ignored.
// - abort in any state -> IDLE next cycle; o_done=0, no further writes; pending write not issued.
// - arm and abort in same cycle: abort wins.
// - Step limit: counter compare is CNT_W unsigned, no overflow; limit >= DEPTH-pretrig behaves as limit off.
// TESTING (ADDR_W=4, DEPTH=16)
// - free-run, pretrig=4, trigger high at 10th sample -> trig_addr=9; 12 post writes incl trigger; done; last addr=4.
// - trigger held high from arm, pretrig=4 -> trigger ignored in PRE; trig_addr=4; 12 post samples then done.
// - limit_en=1, limit=3, pretrig=2 -> exactly 3 writes from trigger inclusive, then done; limit=0 -> 1 write.
// - step_mode=1, 5 slow step pulses, trigger on 3rd -> exactly 5 o_wr_en pulses, addr 0..4; none between pulses.
// - abort during POST -> IDLE next cycle, o_done stays 0; arm+abort same cycle from IDLE -> stays IDLE.
// - i_reset asserted mid-POST, not aligned to clock -> outputs 0 immediately; re-arm restarts at addr 0.

Source files
------------

// File: rtl/capture_sequencer.sv
// Logic-analyzer capture sequencer: arm, pre-trigger fill, trigger wait, post-trigger count, done.
// Generates the circular sample-buffer write strobe/address and records where the trigger landed.
module capture_sequencer #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_arm,
  input  logic              i_abort,
  input  logic              i_step_mode,
  input  logic              i_single_step,
  input  logic [ADDR_W-1:0] i_pretrig,
  input  logic              i_step_limit_en,
  input  logic [CNT_W-1:0]  i_step_limit,
  input  logic              i_trigger,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [ADDR_W-1:0] o_trig_addr,
  output logic              o_run,
  output logic              o_done,
  output logic [2:0]        o_state
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                step_mode_q, step_mode_d;
  logic [ADDR_W-1:0]   pretrig_q, pretrig_d;
  logic [CNT_W-1:0]    post_len_q, post_len_d;
  logic [ADDR_W-1:0]   pre_cnt_q, pre_cnt_d;
  logic [CNT_W-1:0]    post_cnt_q, post_cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0]   trig_addr_q, trig_addr_d;
  logic                run_q, run_d;
  logic                done_q, done_d;
  logic [2:0]          sync_q, sync_d;

  logic                active_c;
  logic                strobe_c;
  logic [CNT_W-1:0]    room_c;
  logic [CNT_W-1:0]    post_len_arm_c;

  // Two synchronizer stages plus one history stage for rising-edge detection.
  assign sync_d = {sync_q[1:0], i_single_step};

  assign active_c = (state_q == ST_PRE) || (state_q == ST_WAIT) || (state_q == ST_POST);
  assign strobe_c = active_c && (step_mode_q ? (sync_q[1] && !sync_q[2]) : 1'b1);

  // Post-trigger length from the arm-time config; a zero result still captures the trigger sample.
  always_comb begin
    room_c         = CNT_W'(DEPTH) - CNT_W'(i_pretrig);
    post_len_arm_c = room_c;
    if (i_step_limit_en && (i_step_limit < room_c)) begin
      post_len_arm_c = i_step_limit;
    end
    if (post_len_arm_c == '0) begin
      post_len_arm_c = CNT_W'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    step_mode_d = step_mode_q;
    pretrig_d   = pretrig_q;
    post_len_d  = post_len_q;
    pre_cnt_d   = pre_cnt_q;
    post_cnt_d  = post_cnt_q;
    addr_d      = addr_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    trig_addr_d = trig_addr_q;

    if (strobe_c) begin
      wr_en_d   = 1'b1;
      wr_addr_d = addr_q;
      addr_d    = addr_q + ADDR_W'(1);
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (i_arm) begin
          step_mode_d = i_step_mode;
          pretrig_d   = i_pretrig;
          post_len_d  = post_len_arm_c;
          pre_cnt_d   = '0;
          post_cnt_d  = '0;
          addr_d      = '0;
          state_d     = (i_pretrig == '0) ? ST_WAIT : ST_PRE;
        end
      end
      ST_PRE: begin
        if (strobe_c) begin
          pre_cnt_d = pre_cnt_q + ADDR_W'(1);
          if ((pre_cnt_q + ADDR_W'(1)) == pretrig_q) begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (strobe_c && i_trigger) begin
          trig_addr_d = addr_q;
          post_cnt_d  = CNT_W'(1);
          state_d     = (post_len_q == CNT_W'(1)) ? ST_DONE : ST_POST;
        end
      end
      ST_POST: begin
        if (strobe_c) begin
          post_cnt_d = post_cnt_q + CNT_W'(1);
          if ((post_cnt_q + CNT_W'(1)) == post_len_q) begin
            state_d = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides everything, including an arm in the same cycle and the write in flight.
    if (i_abort) begin
      state_d = ST_IDLE;
      wr_en_d = 1'b0;
    end

    run_d  = (state_d == ST_PRE) || (state_d == ST_WAIT) || (state_d == ST_POST);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      step_mode_q <= 1'b0;
      pretrig_q   <= '0;
      post_len_q  <= '0;
      pre_cnt_q   <= '0;
      post_cnt_q  <= '0;
      addr_q      <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      trig_addr_q <= '0;
      run_q       <= 1'b0;
      done_q      <= 1'b0;
      sync_q      <= '0;
    end else begin
      state_q     <= state_d;
      step_mode_q <= step_mode_d;
      pretrig_q   <= pretrig_d;
      post_len_q  <= post_len_d;
      pre_cnt_q   <= pre_cnt_d;
      post_cnt_q  <= post_cnt_d;
      addr_q      <= addr_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      trig_addr_q <= trig_addr_d;
      run_q       <= run_d;
      done_q      <= done_d;
      sync_q      <= sync_d;
    end
  end

  assign o_wr_en     = wr_en_q;
  assign o_wr_addr   = wr_addr_q;
  assign o_trig_addr = trig_addr_q;
  assign o_run       = run_q;
  assign o_done      = done_q;
  assign o_state     = state_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer at DEPTH=16: free-run, limits, single-step, abort, async reset.
module tb_capture_sequencer;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned CNT_W  = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              arm_i, abort_i, step_mode_i, single_step_i, limit_en_i, trigger_i;
  logic [ADDR_W-1:0] pretrig_i;
  logic [CNT_W-1:0]  limit_i;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr, trig_addr;
  logic              run, done;
  logic [2:0]        state;

  int n_cmp = 0;
  int n_bad = 0;
  logic [ADDR_W-1:0] wr_log[$];

  capture_sequencer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .i_arm           (arm_i),
    .i_abort         (abort_i),
    .i_step_mode     (step_mode_i),
    .i_single_step   (single_step_i),
    .i_pretrig       (pretrig_i),
    .i_step_limit_en (limit_en_i),
    .i_step_limit    (limit_i),
    .i_trigger       (trigger_i),
    .o_wr_en         (wr_en),
    .o_wr_addr       (wr_addr),
    .o_trig_addr     (trig_addr),
    .o_run           (run),
    .o_done          (done),
    .o_state         (state)
  );

  always #5 clk = ~clk;

  // Every buffer write seen by the sample RAM, in order.
  always @(negedge clk) begin
    if (wr_en) wr_log.push_back(wr_addr);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic arm(input logic sm, input logic [ADDR_W-1:0] pt, input logic le,
                     input logic [CNT_W-1:0] lim);
    step_mode_i = sm;
    pretrig_i   = pt;
    limit_en_i  = le;
    limit_i     = lim;
    wr_log.delete();
    arm_i = 1'b1;
    tick(1);
    arm_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (!done && k < budget) begin
      tick(1);
      k++;
    end
    check_eq(tag, 32'(done), 32'd1);
  endtask

  task automatic wait_addr(input string tag, input logic [ADDR_W-1:0] a, input int budget);
    int k = 0;
    while (!(wr_en && wr_addr == a) && k < budget) begin
      tick(1);
      k++;
    end
    check_eq(tag, 32'(wr_en && wr_addr == a), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    arm_i = 0; abort_i = 0; step_mode_i = 0; single_step_i = 0;
    limit_en_i = 0; trigger_i = 0; pretrig_i = '0; limit_i = '0;
    tick(2);
    check_eq("rst_state", 32'(state), 32'd0);
    check_eq("rst_run", 32'(run), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_wr_en", 32'(wr_en), 32'd0);
    check_eq("rst_trig_addr", 32'(trig_addr), 32'd0);
    rst = 1'b0;
    tick(1);

    // Free-run, pretrig 4, trigger on the 10th sample.
    arm(1'b0, 4'd4, 1'b0, 32'd0);
    check_eq("t1_state_pre", 32'(state), 32'd1);
    check_eq("t1_run", 32'(run), 32'd1);
    wait_addr("t1_reach8", 4'd8, 40);
    trigger_i = 1'b1;
    wait_done("t1_done", 40);
    trigger_i = 1'b0;
    check_eq("t1_trig_addr", 32'(trig_addr), 32'd9);
    check_eq("t1_writes", 32'(wr_log.size()), 32'd21);
    check_eq("t1_last_addr", 32'(wr_log[wr_log.size()-1]), 32'd4);
    check_eq("t1_state_done", 32'(state), 32'd4);
    check_eq("t1_run_off", 32'(run), 32'd0);
    tick(3);
    check_eq("t1_no_more_writes", 32'(wr_log.size()), 32'd21);
    check_eq("t1_done_held", 32'(done), 32'd1);

    // Trigger high from arm (re-arm from DONE): ignored in PRE.
    trigger_i = 1'b1;
    arm(1'b0, 4'd4, 1'b0, 32'd0);
    check_eq("t2_done_cleared", 32'(done), 32'd0);
    check_eq("t2_state_pre", 32'(state), 32'd1);
    wait_done("t2_done", 40);
    check_eq("t2_trig_addr", 32'(trig_addr), 32'd4);
    check_eq("t2_writes", 32'(wr_log.size()), 32'd16);
    check_eq("t2_first_addr", 32'(wr_log[0]), 32'd0);
    check_eq("t2_last_addr", 32'(wr_log[15]), 32'd15);

    // Step limit 3 with pretrig 2, then limit 0.
    arm(1'b0, 4'd2, 1'b1, 32'd3);
    wait_done("t3_done", 30);
    check_eq("t3_trig_addr", 32'(trig_addr), 32'd2);
    check_eq("t3_writes", 32'(wr_log.size()), 32'd5);
    check_eq("t3_last_addr", 32'(wr_log[4]), 32'd4);
    arm(1'b0, 4'd2, 1'b1, 32'd0);
    wait_done("t3z_done", 30);
    tick(2);
    check_eq("t3z_writes", 32'(wr_log.size()), 32'd3);
    check_eq("t3z_trig_addr", 32'(trig_addr), 32'd2);

    // pretrig 0 goes straight to WAIT; limit 1 finishes on the trigger sample.
    arm(1'b0, 4'd0, 1'b1, 32'd1);
    check_eq("t3p_state_wait", 32'(state), 32'd2);
    wait_done("t3p_done", 10);
    check_eq("t3p_writes", 32'(wr_log.size()), 32'd1);
    check_eq("t3p_trig_addr", 32'(trig_addr), 32'd0);

    // Limit beyond the remaining room behaves as no limit.
    arm(1'b0, 4'd4, 1'b1, 32'd100);
    wait_done("t3l_done", 40);
    check_eq("t3l_writes", 32'(wr_log.size()), 32'd16);

    // Single-step: five slow unaligned pulses, trigger effective on the 3rd.
    arm(1'b1, 4'd2, 1'b1, 32'd3);
    tick(5);
    check_eq("t4_idle_no_writes", 32'(wr_log.size()), 32'd0);
    for (int p = 0; p < 5; p++) begin
      #3 single_step_i = 1'b1;
      #40 single_step_i = 1'b0;
      #57;
      check_eq($sformatf("t4_writes_after_pulse%0d", p), 32'(wr_log.size()), 32'(p + 1));
    end
    tick(1);
    check_eq("t4_done", 32'(done), 32'd1);
    check_eq("t4_trig_addr", 32'(trig_addr), 32'd2);
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("t4_addr%0d", i), 32'(wr_log[i]), 32'(i));
    end

    // Abort during POST, then arm+abort together from IDLE.
    arm(1'b0, 4'd4, 1'b0, 32'd0);
    wait_addr("t5_reach6", 4'd6, 20);
    abort_i = 1'b1;
    tick(1);
    abort_i = 1'b0;
    check_eq("t5_state_idle", 32'(state), 32'd0);
    check_eq("t5_no_pending_write", 32'(wr_en), 32'd0);
    check_eq("t5_run", 32'(run), 32'd0);
    tick(4);
    check_eq("t5_writes", 32'(wr_log.size()), 32'd7);
    check_eq("t5_done", 32'(done), 32'd0);
    arm_i = 1'b1;
    abort_i = 1'b1;
    tick(1);
    arm_i = 1'b0;
    abort_i = 1'b0;
    check_eq("t5_armabort_state", 32'(state), 32'd0);
    tick(2);
    check_eq("t5_armabort_run", 32'(run), 32'd0);

    // Async reset mid-POST, off the clock edge; then re-arm.
    arm(1'b0, 4'd4, 1'b0, 32'd0);
    wait_addr("t6_reach6", 4'd6, 20);
    #3 rst = 1'b1;
    #1;
    check_eq("t6_state", 32'(state), 32'd0);
    check_eq("t6_wr_en", 32'(wr_en), 32'd0);
    check_eq("t6_wr_addr", 32'(wr_addr), 32'd0);
    check_eq("t6_trig_addr", 32'(trig_addr), 32'd0);
    check_eq("t6_run", 32'(run), 32'd0);
    #7 rst = 1'b0;
    tick(1);
    arm(1'b0, 4'd4, 1'b0, 32'd0);
    wait_done("t6_done", 40);
    check_eq("t6_first_addr", 32'(wr_log[0]), 32'd0);
    check_eq("t6_writes", 32'(wr_log.size()), 32'd16);
    check_eq("t6_trig_addr_rearm", 32'(trig_addr), 32'd4);
    trigger_i = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
